// File: rtl/gpio_poll_pkg.sv
// ============================================================================
//  Module      : gpio_poll_pkg
//  Description : Shared register map, CTRL field positions, edge-mode and
//                poll-FSM encodings for the GPIO input polling controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_poll_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_EDGE   = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_MODE_LSB   = 2;
  localparam int CTRL_MASK_LSB   = 8;
  // Only 24 mask bits fit above bit 8 of a 32-bit CTRL word.
  localparam int CTRL_MASK_MAX_W = 24;

  typedef enum logic [1:0] {
    EDGE_ANY  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_CAPTURE = 2'd3
  } poll_state_e;

endpackage

`default_nettype wire

// File: rtl/gpio_poll_edge.sv
// ============================================================================
//  Module      : gpio_poll_edge
//  Description : Holds the sampled DATA value, detects per-bit edges and keeps
//                them in a write-1-to-clear EDGE register. With DEBOUNCE_EN
//                defined, DATA only follows DEB_SAMPLES identical samples.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_poll_edge
  import gpio_poll_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEB_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_sample_vld,
  input  logic [WIDTH-1:0] i_sample,
  input  edge_mode_e       i_mode,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [WIDTH-1:0] i_w1c,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_edge;
  logic             r_primed;
  logic             w_accept;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_set;

`ifdef DEBOUNCE_EN
  localparam int               c_cnt_w   = $clog2(DEB_SAMPLES + 1);
  localparam logic [c_cnt_w-1:0] c_deb_max = c_cnt_w'(DEB_SAMPLES);

  logic [c_cnt_w-1:0] r_deb_cnt;
  logic [WIDTH-1:0]   r_deb_last;
  logic [c_cnt_w-1:0] w_deb_next;

  always_comb begin
    w_deb_next = c_cnt_w'(1);
    if (r_deb_cnt != '0 && i_sample == r_deb_last) begin
      w_deb_next = (r_deb_cnt == c_deb_max) ? c_deb_max : r_deb_cnt + 1'b1;
    end
  end

  assign w_accept = i_sample_vld && (w_deb_next == c_deb_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb_cnt  <= '0;
      r_deb_last <= '0;
    end else if (i_clear) begin
      r_deb_cnt  <= '0;
    end else if (i_sample_vld) begin
      r_deb_cnt  <= w_deb_next;
      r_deb_last <= i_sample;
    end
  end
`else
  localparam int c_unused_deb = DEB_SAMPLES;

  assign w_accept = i_sample_vld;
`endif

  assign w_rise = i_sample & ~r_data;
  assign w_fall = ~i_sample & r_data;

  always_comb begin
    w_sel = '0;
    case (i_mode)
      EDGE_ANY:  w_sel = w_rise | w_fall;
      EDGE_RISE: w_sel = w_rise;
      EDGE_FALL: w_sel = w_fall;
      default:   w_sel = '0;
    endcase
  end

  // The very first accepted sample after enable only seeds DATA.
  assign w_set = (w_accept && r_primed) ? (w_sel & i_mask) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_primed <= 1'b0;
    end else if (i_clear) begin
      r_primed <= 1'b0;
    end else if (w_accept) begin
      r_data   <= i_sample;
      r_primed <= 1'b1;
    end
  end

  // A new edge on a bit beats a simultaneous host clear of that bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~i_w1c) | w_set;
    end
  end

  assign o_data = r_data;
  assign o_edge = r_edge;

endmodule

`default_nettype wire

// File: rtl/gpio_in_poll_ctrl.sv
// ============================================================================
//  Module      : gpio_in_poll_ctrl
//  Description : Avalon-MM poller for a GPIO input PIO: periodic master reads,
//                edge capture with interrupt, 4-register host slave port.
//                Optional input debounce is compiled in with DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_in_poll_ctrl
  import gpio_poll_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PERIOD_RST  = 1000,
  parameter int DATA_ADDR   = 0,
  parameter int DEB_SAMPLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  output logic        irq
);

  localparam int          c_mask_w     = (WIDTH > CTRL_MASK_MAX_W) ? CTRL_MASK_MAX_W : WIDTH;
  localparam logic [31:0] c_ctrl_wmask = 32'h0000_000F |
                                         (((32'd1 << c_mask_w) - 32'd1) << CTRL_MASK_LSB);

  logic [31:0]      r_ctrl;
  logic [15:0]      r_period;
  logic [15:0]      r_cnt;
  poll_state_e      r_state;
  logic [31:0]      r_s_readdata;
  logic             r_irq;

  logic             w_enable;
  logic             w_irq_en;
  edge_mode_e       w_mode;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_sample;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_edge;
  logic [15:0]      w_reload;
  logic             w_sample_vld;

  assign w_enable = r_ctrl[CTRL_ENABLE_BIT];
  assign w_irq_en = r_ctrl[CTRL_IRQ_EN_BIT];
  assign w_mode   = edge_mode_e'(r_ctrl[CTRL_MODE_LSB +: 2]);

  // Bits with no room in CTRL are permanently masked off.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    if (gi < c_mask_w) begin : g_mapped
      assign w_mask[gi] = r_ctrl[CTRL_MASK_LSB + gi];
    end else begin : g_unmapped
      assign w_mask[gi] = 1'b0;
    end
  end

  if (WIDTH < 32) begin : g_rd_unused
    logic w_unused_rd;
    assign w_unused_rd = ^m_readdata[31:WIDTH];
  end

  assign w_reload     = (r_period == 16'd0) ? 16'd0 : r_period - 16'd1;
  assign w_w1c        = (s_write && s_address == REG_EDGE) ? s_writedata[WIDTH-1:0] : '0;
  assign w_sample     = m_readdata[WIDTH-1:0];
  assign w_sample_vld = w_enable && (r_state == ST_CAPTURE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_period <= 16'(PERIOD_RST);
    end else if (s_write) begin
      case (s_address)
        REG_CTRL:   r_ctrl   <= s_writedata & c_ctrl_wmask;
        REG_PERIOD: r_period <= s_writedata[15:0];
        default:    ;
      endcase
    end
  end

  // Clearing enable aborts any in-flight poll; CAPTURE is then never taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (!w_enable) begin
      r_state <= ST_IDLE;
      r_cnt   <= w_reload;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_COUNT;
          r_cnt   <= w_reload;
        end
        ST_COUNT: begin
          if (r_cnt == 16'd0) begin
            r_state <= ST_ISSUE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_CAPTURE;
        end
        default: begin
          r_state <= ST_COUNT;
          r_cnt   <= w_reload;
        end
      endcase
    end
  end

  gpio_poll_edge #(
    .WIDTH       (WIDTH),
    .DEB_SAMPLES (DEB_SAMPLES)
  ) u_edge (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (!w_enable),
    .i_sample_vld (w_sample_vld),
    .i_sample     (w_sample),
    .i_mode       (w_mode),
    .i_mask       (w_mask),
    .i_w1c        (w_w1c),
    .o_data       (w_data),
    .o_edge       (w_edge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_readdata <= '0;
    end else if (s_read) begin
      case (s_address)
        REG_CTRL:   r_s_readdata <= r_ctrl;
        REG_PERIOD: r_s_readdata <= {16'd0, r_period};
        REG_EDGE:   r_s_readdata <= 32'(w_edge);
        default:    r_s_readdata <= 32'(w_data);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_en & (|w_edge);
    end
  end

  assign s_readdata = r_s_readdata;
  assign m_address  = 2'(DATA_ADDR);
  assign m_read     = (r_state == ST_ISSUE);
  assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_gpio_in_poll_ctrl.sv
// ============================================================================
//  Module      : tb_gpio_in_poll_ctrl
//  Description : Directed self-checking bench for gpio_in_poll_ctrl with a
//                one-cycle-latency PIO model on the master port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_in_poll_ctrl;

`ifdef DEBOUNCE_EN
  localparam int c_deb = 3;
`else
  localparam int c_deb = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  s_address = 2'd0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic        s_read = 1'b0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata = 32'hBAD0_BA5A;
  logic        irq;

  logic [7:0]  pio_val = 8'h00;
  int          vectors = 0;
  int          errors  = 0;

  gpio_in_poll_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .s_address   (s_address),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .s_read      (s_read),
    .s_readdata  (s_readdata),
    .m_address   (m_address),
    .m_read      (m_read),
    .m_readdata  (m_readdata),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // PIO answers one cycle after m_read; garbage otherwise.
  always @(posedge clk) begin
    m_readdata <= m_read ? {24'hDEAD5A, pio_val} : 32'hBAD0_BA5A;
  end

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    s_address   = addr;
    s_writedata = data;
    s_write     = 1'b1;
    @(negedge clk);
    s_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    s_address = addr;
    s_read    = 1'b1;
    @(negedge clk);
    s_read    = 1'b0;
    data      = s_readdata;
  endtask

  task automatic wait_mread(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_read) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_polls(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_mread(ok);
      vectors++;
      if (!ok) begin
        $display("FAIL poll_timeout: got no m_read, expected one within 200 cycles");
        errors++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_readdata !== 32'd0 || m_read !== 1'b0 || irq !== 1'b0 || m_address !== 2'd0) begin
      $display("FAIL reset_outputs: got rd=%h mr=%b irq=%b ma=%h, expected all 0",
               s_readdata, m_read, irq, m_address);
      errors++;
    end
    bus_read(2'd1, rd);
    vectors++;
    if (rd !== 32'd1000) begin
      $display("FAIL reset_period: got %0d expected 1000", rd);
      errors++;
    end
    bus_write(2'd1, 32'd40);
    bus_write(2'd0, 32'h1);
    repeat (20) @(negedge clk);
    bus_read(2'd1, rd);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (s_readdata !== 32'd0 || m_read !== 1'b0 || irq !== 1'b0) begin
      $display("FAIL reset_midcount: got rd=%h mr=%b irq=%b expected all 0",
               s_readdata, m_read, irq);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    bus_read(2'd1, rd);
    vectors++;
    if (rd !== 32'd1000) begin
      $display("FAIL reset_period_restore: got %0d expected 1000", rd);
      errors++;
    end
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'd0) begin
      $display("FAIL reset_ctrl: got %h expected 0", rd);
      errors++;
    end
    begin
      int seen = 0;
      for (int k = 0; k < 2100; k++) begin
        @(negedge clk);
        if (m_read) seen++;
      end
      vectors++;
      if (seen != 0) begin
        $display("FAIL reset_no_poll: got %0d m_read pulses expected 0", seen);
        errors++;
      end
    end
  endtask

  task automatic test_cadence;
    logic [31:0] rd;
    bit ok;
    int n;
    pio_val = 8'hA5;
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h1);
    wait_mread(ok);
    vectors++;
    if (!ok || m_address !== 2'd0) begin
      $display("FAIL cadence_first: got ok=%b addr=%h expected 1/0", ok, m_address);
      errors++;
    end
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          vectors++;
          if (m_read !== 1'b0) begin
            $display("FAIL cadence_width: got m_read=%b expected 0", m_read);
            errors++;
          end
        end
      end while (!m_read && n < 50);
      vectors++;
      if (n != 7) begin
        $display("FAIL cadence_interval: got %0d cycles expected 7", n);
        errors++;
      end
    end
    wait_polls(c_deb + 1);
    bus_read(2'd3, rd);
    vectors++;
    if (rd !== 32'hA5) begin
      $display("FAIL cadence_data: got %h expected a5", rd);
      errors++;
    end
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_rising;
    logic [31:0] rd;
    pio_val = 8'h00;
    bus_write(2'd0, 32'h0000_FF07);
    wait_polls(c_deb + 2);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      $display("FAIL rise_prime: got edge=%h irq=%b expected 0/0", rd, irq);
      errors++;
    end
    pio_val = 8'h81;
    wait_polls(c_deb + 1);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h81 || irq !== 1'b1) begin
      $display("FAIL rise_edge: got edge=%h irq=%b expected 81/1", rd, irq);
      errors++;
    end
    bus_write(2'd2, 32'h01);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h80 || irq !== 1'b1) begin
      $display("FAIL rise_w1c_bit0: got edge=%h irq=%b expected 80/1", rd, irq);
      errors++;
    end
    bus_write(2'd2, 32'h80);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      $display("FAIL rise_w1c_bit7: got edge=%h irq=%b expected 0/0", rd, irq);
      errors++;
    end
    pio_val = 8'h00;
    wait_polls(c_deb + 1);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h0) begin
      $display("FAIL rise_ignores_fall: got edge=%h expected 0", rd);
      errors++;
    end
    bus_read(2'd3, rd);
    vectors++;
    if (rd !== 32'h0) begin
      $display("FAIL rise_data: got %h expected 0", rd);
      errors++;
    end
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_falling;
    logic [31:0] rd;
    pio_val = 8'hFF;
    bus_write(2'd0, 32'h0000_FF01);
    wait_polls(c_deb + 1);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h0) begin
      $display("FAIL fall_first_sample: got edge=%h expected 0", rd);
      errors++;
    end
    bus_write(2'd0, 32'h0);
    pio_val = 8'h00;
    bus_write(2'd0, 32'h0000_0F09);
    wait_polls(c_deb + 1);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h0) begin
      $display("FAIL fall_reenable_prime: got edge=%h expected 0", rd);
      errors++;
    end
    pio_val = 8'hFF;
    wait_polls(c_deb + 1);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h0) begin
      $display("FAIL fall_ignores_rise: got edge=%h expected 0", rd);
      errors++;
    end
    pio_val = 8'h00;
    wait_polls(c_deb + 1);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h0F || irq !== 1'b0) begin
      $display("FAIL fall_masked: got edge=%h irq=%b expected 0f/0", rd, irq);
      errors++;
    end
    bus_write(2'd2, 32'hFF);
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_collision;
    logic [31:0] rd;
    bit ok;
    pio_val = 8'h00;
    bus_write(2'd0, 32'h0000_0105);
    wait_polls(c_deb + 1);
    for (int k = 1; k <= c_deb; k++) begin
      wait_mread(ok);
      vectors++;
      if (!ok) begin
        $display("FAIL collide_timeout: got no m_read expected one");
        errors++;
      end
      if (k == 1) pio_val = 8'h01;
    end
    @(negedge clk);
    s_address   = 2'd2;
    s_writedata = 32'h1;
    s_write     = 1'b1;
    @(negedge clk);
    s_write     = 1'b0;
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h1) begin
      $display("FAIL collide_set_wins: got edge=%h expected 01", rd);
      errors++;
    end
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h0) begin
      $display("FAIL collide_clear: got edge=%h expected 0", rd);
      errors++;
    end
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_disable;
    logic [31:0] rd;
    bit ok;
    int n;
    int seen;
    pio_val = 8'h3C;
    bus_write(2'd0, 32'h0000_FF01);
    wait_polls(c_deb + 1);
    pio_val = 8'hC3;
    wait_mread(ok);
    s_address   = 2'd0;
    s_writedata = 32'h0;
    s_write     = 1'b1;
    @(negedge clk);
    s_write     = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_read) seen++;
    end
    vectors++;
    if (!ok || seen != 0) begin
      $display("FAIL disable_idle: got ok=%b pulses=%0d expected 1/0", ok, seen);
      errors++;
    end
    bus_read(2'd3, rd);
    vectors++;
    if (rd !== 32'h3C) begin
      $display("FAIL disable_data_kept: got %h expected 3c", rd);
      errors++;
    end
    bus_write(2'd0, 32'h0000_FF01);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_read && n < 50);
    vectors++;
    if (n != 6) begin
      $display("FAIL disable_restart: got first poll after %0d cycles expected 6", n);
      errors++;
    end
    wait_polls(c_deb + 1);
    bus_read(2'd3, rd);
    vectors++;
    if (rd !== 32'hC3) begin
      $display("FAIL disable_reprime_data: got %h expected c3", rd);
      errors++;
    end
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'h0) begin
      $display("FAIL disable_reprime_edge: got %h expected 0", rd);
      errors++;
    end
    bus_write(2'd0, 32'h0);
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_debounce;
    logic [31:0] rd;
    logic [7:0]  seq [5];
    logic [31:0] exp_data [5];
    bit ok;
    seq      = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01};
    exp_data = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    pio_val = 8'h00;
    bus_write(2'd0, 32'h0000_FF01);
    wait_polls(4);
    for (int i = 0; i < 5; i++) begin
      wait_mread(ok);
      pio_val = seq[i];
      repeat (2) @(negedge clk);
      bus_read(2'd3, rd);
      vectors++;
      if (!ok || rd !== exp_data[i]) begin
        $display("FAIL debounce_step%0d: got data=%h ok=%b expected %h", i, rd, ok, exp_data[i]);
        errors++;
      end
    end
    bus_write(2'd0, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_cadence();
    test_rising();
    test_falling();
    test_collision();
    test_disable();
`ifdef DEBOUNCE_EN
    test_debounce();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpio_in_poll_ctrl.md
Name: gpio_in_poll_ctrl

Overview:
- Avalon-MM controller that sequences the 8-bit GPIO input PIO.
- Issues periodic reads to the PIO data register through its master port and keeps the last sampled value.
- Detects per-bit edges, latches them in a write-1-to-clear capture register, and raises an interrupt.
- Sits between the PIO slave and the Nios/host bus; the host configures it through a 4-register slave port.

Parameters:
- WIDTH, 8, sampled input width (1..32); PIO readdata bits above WIDTH are ignored.
- PERIOD_RST, 1000, reset value of PERIOD (clk cycles between polls).
- DATA_ADDR, 0, PIO register address driven on m_address.
- DEB_SAMPLES, 3, consecutive equal samples needed; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_address  in  2  host register select
- s_write  in  1  host write strobe
- s_writedata  in  32  host write data
- s_read  in  1  host read strobe
- s_readdata  out  32  host read data, registered, latency 1
- m_address  out  2  PIO address, constant DATA_ADDR
- m_read  out  1  one-cycle poll strobe
- m_readdata  in  32  PIO readdata, valid exactly 1 cycle after m_read
- irq  out  1  level interrupt

Behaviour:
- Register map:
  - 0 CTRL: [0] enable, [1] irq_en, [3:2] edge mode (00 any, 01 rising, 10 falling, 11 none), [8+WIDTH-1:8] mask.
  - 1 PERIOD: [15:0]; a value of 0 is treated as 1.
  - 2 EDGE: [WIDTH-1:0], write-1-to-clear.
  - 3 DATA: [WIDTH-1:0], read-only; writes are ignored.
  - Unused read bits return 0.
- Reset values: s_readdata=0, m_read=0, irq=0, CTRL=0, PERIOD=PERIOD_RST, EDGE=0, DATA=0, primed=0, FSM=IDLE.
- FSM states:
  - IDLE: counter loaded with PERIOD-1. Go to COUNT when enable=1.
  - COUNT: decrement each cycle. At 0 go to ISSUE.
  - ISSUE: m_read=1 for exactly one cycle. Go to CAPTURE.
  - CAPTURE: sample m_readdata[WIDTH-1:0]. Update DATA and EDGE. Reload the counter. Go to COUNT.
- Enable cleared in any state: go to IDLE next cycle. An in-flight sample is discarded. DATA and EDGE are retained. primed is cleared.
- Poll interval equals PERIOD+2 cycles from ISSUE to ISSUE; with PERIOD=1 this is 3.
- Edge detection at CAPTURE, with new = sample and old = DATA:
  - rising = new & ~old
  - falling = ~new & old
  - EDGE |= sel & mask, where sel follows the edge mode.
- First CAPTURE after enable (primed=0): load DATA only, no edges, then set primed.
- Simultaneous host W1C on EDGE and a new edge on the same bit: the set wins.
- PERIOD written while counting: takes effect at the next reload; the current count continues.
- irq = irq_en & |EDGE, registered, asserted the cycle after EDGE becomes non-zero.
- Host read: s_readdata updated the cycle after s_read. When s_read=0 it holds its value.

Optional Feature:
- DEBOUNCE_EN defined:
  - A sample updates DATA only after DEB_SAMPLES consecutive identical samples.
  - Edge detection uses the debounced DATA.
  - The stability counter resets on mismatch and when enable is cleared.
  - The first DATA load after enable also requires DEB_SAMPLES equal samples.
- DEBOUNCE_EN undefined: every CAPTURE updates DATA directly. No stability counter logic is generated.

Decomposition:
- Shared package gpio_poll_pkg holds:
  - register address constants (REG_CTRL=0, REG_PERIOD=1, REG_EDGE=2, REG_DATA=3)
  - CTRL bit-position constants
  - edge-mode enum
  - FSM state enum (IDLE, COUNT, ISSUE, CAPTURE)
- Sub-module gpio_poll_edge: combinational edge select plus EDGE register with W1C. The debounce counter, when compiled in, also lives there.

Test Plan:
- Reset: assert reset mid-COUNT -> all outputs 0, PERIOD reads 1000, no m_read for ≥2000 cycles.
- Poll cadence: PERIOD=5, enable=1 -> m_read pulses every 7 cycles, m_address=0; DATA follows the PIO value 0xA5.
- Rising edge: mode 01, mask 0xFF, irq_en=1, input 0x00->0x81 -> EDGE=0x81, irq=1. Write 0x01 to EDGE -> EDGE=0x80, irq stays 1. Write 0x80 -> irq=0.
- Falling edge with mask: mode 10, mask 0x0F, input 0xFF->0x00 -> EDGE=0x0F. First sample after enable produces no edge.
- Collision: W1C to bit0 in the same cycle as a new bit0 edge -> EDGE[0]=1.
- Disable: clear enable during ISSUE -> CAPTURE skipped, FSM in IDLE, DATA unchanged. With DEBOUNCE_EN and glitch sequence 1,0,1,1,1 -> DATA becomes 1 only after the third consecutive 1.
